// File: rtl/fanout_pkg.sv
// Shared definitions for the stream fork (fanout) family.
//
// Contents:
//   MAX_BRANCHES        upper bound on the number of downstream branches
//   CFG_EN_BIT_DEFAULT  default position of the "branch used" bit inside a config word
//   fork_mode_e         lazy (legacy all-or-nothing) or eager (per-branch taken flags) fork
package fanout_pkg;

    localparam int MAX_BRANCHES       = 8;
    localparam int CFG_EN_BIT_DEFAULT = 20;

    typedef enum logic {
        FORK_LAZY  = 1'b0,
        FORK_EAGER = 1'b1
    } fork_mode_e;

endpackage

// File: rtl/fanout_ready_reduce.sv
// Ready AND-reduction for the stream fork.
//
// A branch contributes to the reduction only when it is active; an inactive
// branch always counts as ready. Each ready_term bit already folds in whatever
// makes a branch "done" (its dn_ready, or its taken flag in eager mode).
//
// Ports:
//   active        in   N   branch participates in the fork
//   ready_term    in   N   branch is ready or already done with the token
//   all_ready     out  1   every active branch is ready/done
//   others_ready  out  N   bit i: every active branch other than i is ready/done
module fanout_ready_reduce #(
    parameter int NUM_BRANCHES = 3
) (
    input  logic [NUM_BRANCHES-1:0] active,
    input  logic [NUM_BRANCHES-1:0] ready_term,
    output logic                    all_ready,
    output logic [NUM_BRANCHES-1:0] others_ready
);

    logic [NUM_BRANCHES-1:0] branch_ok;

    assign branch_ok = ~active | ready_term;
    assign all_ready = &branch_ok;

    // others_ready[i] excludes branch i itself, so a branch's valid never
    // depends combinationally on its own ready.
    always_comb begin
        others_ready = '1;
        for (int i = 0; i < NUM_BRANCHES; i++) begin
            for (int j = 0; j < NUM_BRANCHES; j++) begin
                if (j != i) begin
                    others_ready[i] = others_ready[i] & branch_ok[j];
                end
            end
        end
    end

endmodule

// File: rtl/fanout_fork_eager.sv
// Parametrised stream fork: one valid/ready upstream channel broadcast to
// NUM_BRANCHES downstream channels, with an optional eager mode in which each
// branch accepts the token independently and the upstream is acked once all
// active branches have taken it. Pure combinational data path, no storage.
//
// Ports:
//   clk         in   1                        clock
//   reset       in   1                        synchronous, active-high reset
//   mode_eager  in   1                        1 = eager fork, 0 = lazy fork
//   flush       in   1                        clear taken flags
//   en          in   NUM_BRANCHES             per-branch enable
//   cfg         in   NUM_BRANCHES*CFG_WIDTH   per-branch config words
//   up_data     in   DATA_WIDTH               upstream payload
//   up_valid    in   1                        upstream valid
//   up_ready    out  1                        upstream ready
//   dn_data     out  NUM_BRANCHES*DATA_WIDTH  per-branch payload (copy of up_data)
//   dn_valid    out  NUM_BRANCHES             per-branch valid
//   dn_ready    in   NUM_BRANCHES             per-branch ready
//   tok_count   out  CNT_WIDTH                saturating count of consumed tokens
module fanout_fork_eager
    import fanout_pkg::*;
#(
    parameter int NUM_BRANCHES = 3,
    parameter int DATA_WIDTH   = 17,
    parameter int CFG_WIDTH    = 32,
    parameter int CFG_EN_BIT   = CFG_EN_BIT_DEFAULT,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mode_eager,
    input  logic                              flush,
    input  logic [NUM_BRANCHES-1:0]           en,
    input  logic [NUM_BRANCHES*CFG_WIDTH-1:0] cfg,
    input  logic [DATA_WIDTH-1:0]             up_data,
    input  logic                              up_valid,
    output logic                              up_ready,
    output logic [NUM_BRANCHES*DATA_WIDTH-1:0] dn_data,
    output logic [NUM_BRANCHES-1:0]           dn_valid,
    input  logic [NUM_BRANCHES-1:0]           dn_ready,
    output logic [CNT_WIDTH-1:0]              tok_count
);

    fork_mode_e              mode;
    logic [NUM_BRANCHES-1:0] active;
    logic [NUM_BRANCHES-1:0] taken;
    logic [NUM_BRANCHES-1:0] taken_next;
    logic [NUM_BRANCHES-1:0] ready_term;
    logic [NUM_BRANCHES-1:0] others_ready;
    logic                    all_ready;
    logic                    up_fire;
    logic                    cfg_unused;

    assign mode = mode_eager ? FORK_EAGER : FORK_LAZY;

    // Only the enable bit of each config word matters here; the rest of the
    // word belongs to other consumers of the same config bus.
    always_comb begin
        active = '0;
        for (int i = 0; i < NUM_BRANCHES; i++) begin
            active[i] = en[i] & cfg[i*CFG_WIDTH + CFG_EN_BIT];
        end
    end

    assign cfg_unused = ^cfg;

    // In eager mode a branch that already took the token counts as ready.
    // taken is held at zero in lazy mode, so the gating is only for clarity.
    assign ready_term = (mode == FORK_EAGER) ? (dn_ready | taken) : dn_ready;

    fanout_ready_reduce #(
        .NUM_BRANCHES (NUM_BRANCHES)
    ) u_ready_reduce (
        .active       (active),
        .ready_term   (ready_term),
        .all_ready    (all_ready),
        .others_ready (others_ready)
    );

    assign up_ready = all_ready;
    assign up_fire  = up_valid & up_ready;
    assign dn_data  = {NUM_BRANCHES{up_data}};

    // Eager: offer the token to every active branch that has not taken it yet.
    // Lazy: offer only when every other active branch is ready too, so all
    // branches transfer on the same cycle.
    always_comb begin
        if (mode == FORK_EAGER) begin
            dn_valid = {NUM_BRANCHES{up_valid}} & active & ~taken;
        end else begin
            dn_valid = {NUM_BRANCHES{up_valid}} & active & others_ready;
        end
    end

    // Flush and a completed token both restart the branch bookkeeping;
    // leaving eager mode drops any partial progress.
    always_comb begin
        taken_next = taken | (dn_valid & dn_ready);
        if (flush || up_fire || (mode != FORK_EAGER)) begin
            taken_next = '0;
        end
    end

    // Taken flags and the saturating token counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken     <= '0;
            tok_count <= '0;
        end else begin
            taken <= taken_next;
            if (up_fire && (tok_count != {CNT_WIDTH{1'b1}})) begin
                tok_count <= tok_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fanout_fork_eager.sv
// Directed testbench for fanout_fork_eager (3 branches, 4-bit token counter).
// Inputs change on the falling edge; outputs are compared 1 time unit later.
module tb_fanout_fork_eager;

    localparam int NB  = 3;
    localparam int DW  = 17;
    localparam int CW  = 32;
    localparam int CNW = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                mode_eager;
    logic                flush;
    logic [NB-1:0]       en;
    logic [NB*CW-1:0]    cfg;
    logic [DW-1:0]       up_data;
    logic                up_valid;
    logic                up_ready;
    logic [NB*DW-1:0]    dn_data;
    logic [NB-1:0]       dn_valid;
    logic [NB-1:0]       dn_ready;
    logic [CNW-1:0]      tok_count;

    int checks = 0;
    int passed = 0;

    localparam logic [NB*CW-1:0] CFG_ALL  = {NB{32'h0010_0000}};
    localparam logic [NB*CW-1:0] CFG_NO1  = {32'h0010_0000, 32'h0000_0000, 32'h0010_0000};

    fanout_fork_eager #(
        .NUM_BRANCHES (NB),
        .DATA_WIDTH   (DW),
        .CFG_WIDTH    (CW),
        .CFG_EN_BIT   (20),
        .CNT_WIDTH    (CNW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode_eager (mode_eager),
        .flush      (flush),
        .en         (en),
        .cfg        (cfg),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .dn_data    (dn_data),
        .dn_valid   (dn_valid),
        .dn_ready   (dn_ready),
        .tok_count  (tok_count)
    );

    always #5 clk = ~clk;

    // Drive all functional inputs at once on a falling edge boundary.
    task automatic applyStimulus(input logic eager, input logic [NB-1:0] en_v,
                                 input logic [NB*CW-1:0] cfg_v, input logic uv,
                                 input logic [NB-1:0] dr, input logic fl);
        mode_eager = eager;
        en         = en_v;
        cfg        = cfg_v;
        up_valid   = uv;
        dn_ready   = dr;
        flush      = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        nextCycle();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        up_data  = 17'h1abcd;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);

        // Reset state
        doReset();
        #1;
        checkOutput("reset_count", 32'(tok_count), 32'd0);
        checkOutput("reset_dn_valid", 32'(dn_valid), 32'd0);

        // T1: lazy, all active, one branch not ready
        applyStimulus(1'b0, 3'b111, CFG_ALL, 1'b1, 3'b011, 1'b0);
        checkOutput("t1_up_ready_blocked", 32'(up_ready), 32'd0);
        checkOutput("t1_dn_valid_blocked", 32'(dn_valid), 32'b100);
        checkOutput("t1_dn_data2", 32'(dn_data[2*DW +: DW]), 32'h1abcd);
        applyStimulus(1'b0, 3'b111, CFG_ALL, 1'b1, 3'b111, 1'b0);
        checkOutput("t1_up_ready", 32'(up_ready), 32'd1);
        checkOutput("t1_dn_valid", 32'(dn_valid), 32'b111);
        nextCycle();
        applyStimulus(1'b0, 3'b111, CFG_ALL, 1'b0, 3'b111, 1'b0);
        checkOutput("t1_count", 32'(tok_count), 32'd1);

        // T2: eager, branches accept one at a time
        doReset();
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b001, 1'b0);
        checkOutput("t2_c1_dn_valid", 32'(dn_valid), 32'b111);
        checkOutput("t2_c1_up_ready", 32'(up_ready), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b010, 1'b0);
        checkOutput("t2_c2_dn_valid", 32'(dn_valid), 32'b110);
        checkOutput("t2_c2_up_ready", 32'(up_ready), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b100, 1'b0);
        checkOutput("t2_c3_dn_valid", 32'(dn_valid), 32'b100);
        checkOutput("t2_c3_up_ready", 32'(up_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b000, 1'b0);
        checkOutput("t2_count", 32'(tok_count), 32'd1);
        checkOutput("t2_taken_cleared", 32'(dn_valid), 32'b111);
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b0, 3'b000, 1'b0);

        // T3: eager, branch 1 unconfigured
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 3'b111, CFG_NO1, 1'b1, 3'b101, 1'b0);
            checkOutput("t3_up_ready", 32'(up_ready), 32'd1);
            checkOutput("t3_dn_valid", 32'(dn_valid), 32'b101);
            nextCycle();
        end
        applyStimulus(1'b1, 3'b111, CFG_NO1, 1'b0, 3'b101, 1'b0);
        checkOutput("t3_count", 32'(tok_count), 32'd3);

        // T4: no active branch acts as a sink
        doReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 3'b000, CFG_ALL, 1'b1, 3'b000, 1'b0);
            checkOutput("t4_up_ready", 32'(up_ready), 32'd1);
            checkOutput("t4_dn_valid", 32'(dn_valid), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b0, 3'b000, CFG_ALL, 1'b0, 3'b000, 1'b0);
        checkOutput("t4_count", 32'(tok_count), 32'd10);

        // T5: flush re-offers a partially taken token
        doReset();
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b001, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b000, 1'b1);
        checkOutput("t5_taken_001", 32'(dn_valid), 32'b110);
        nextCycle();
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b000, 1'b0);
        checkOutput("t5_reoffer", 32'(dn_valid), 32'b111);
        checkOutput("t5_count_0", 32'(tok_count), 32'd0);
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b111, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b0, 3'b000, 1'b0);
        checkOutput("t5_flush_fire_count", 32'(tok_count), 32'd1);

        // T6: reset clears taken and count mid-token
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b111, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b011, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b000, 1'b0);
        checkOutput("t6_pre_count", 32'(tok_count), 32'd5);
        checkOutput("t6_pre_taken", 32'(dn_valid), 32'b100);
        reset = 1'b1;
        nextCycle();
        #1;
        checkOutput("t6_rst_count", 32'(tok_count), 32'd0);
        checkOutput("t6_rst_taken", 32'(dn_valid), 32'b111);
        reset = 1'b0;

        // T6b: counter saturation
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b1, 3'b111, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 3'b111, CFG_ALL, 1'b0, 3'b111, 1'b0);
        checkOutput("t6_saturate", 32'(tok_count), 32'd15);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
